fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 38 +++
 rtl/fetch_controller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Fetch controller bus: control inputs, instruction memory port and issue outputs.
// cycleCount is only present when CYCLE_COUNT_EN is defined.
interface fetch_controller_if;
  logic        start;
  logic [1:0]  programSelectIn;
  logic        stall;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic [15:0] instruction;
  logic [7:0]  address;
  logic [1:0]  programSelect;
  logic [15:0] instrOut;
  logic        instrValid;
  logic        busy;
  logic        done;
  logic        fault;
`ifdef CYCLE_COUNT_EN
  logic [15:0] cycleCount;

  modport master (
    input  start, programSelectIn, stall, branchTaken, branchTarget, instruction,
    output address, programSelect, instrOut, instrValid, busy, done, fault, cycleCount
  );
  modport slave (
    output start, programSelectIn, stall, branchTaken, branchTarget, instruction,
    input  address, programSelect, instrOut, instrValid, busy, done, fault, cycleCount
  );
`else
  modport master (
    input  start, programSelectIn, stall, branchTaken, branchTarget, instruction,
    output address, programSelect, instrOut, instrValid, busy, done, fault
  );
  modport slave (
    output start, programSelectIn, stall, branchTaken, branchTarget, instruction,
    input  address, programSelect, instrOut, instrValid, busy, done, fault
  );
`endif
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues one word per cycle, honours stall, branch and halt.
// Optional busy-cycle counter enabled by defining CYCLE_COUNT_EN.
module fetch_controller #(
  parameter int unsigned MEM_DEPTH   = 128,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input logic          clk,
  input logic          rst_n,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);
  localparam logic [8:0] DEPTH_9   = 9'(MEM_DEPTH);

  state_t      state, state_next;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        accept_start;
  logic        target_oob;
  logic        is_halt;

  assign accept_start = bus.start && (state == IDLE || state == DONE);
  assign target_oob   = {1'b0, bus.branchTarget} >= DEPTH_9;
  assign is_halt      = bus.instruction[15:12] == HALT_OPCODE;

  always_comb begin
    state_next = state;
    addr_d     = addr_q;
    sel_d      = sel_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    fault_d    = fault_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          sel_d      = bus.programSelectIn;
          addr_d     = '0;
          fault_d    = 1'b0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // Priority: stall, then branch, then halt / end-of-memory, then plain issue.
        if (bus.stall) begin
          state_next = HOLD;
        end else if (bus.branchTaken) begin
          if (target_oob) begin
            fault_d    = 1'b1;
            state_next = DONE;
          end else begin
            addr_d = bus.branchTarget;
          end
        end else begin
          instr_d = bus.instruction;
          valid_d = 1'b1;
          if (is_halt) begin
            state_next = DONE;
          end else if (addr_q == LAST_ADDR) begin
            fault_d    = 1'b1;
            state_next = DONE;
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (!bus.stall) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      sel_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign bus.address       = addr_q;
  assign bus.programSelect = sel_q;
  assign bus.instrOut      = instr_q;
  assign bus.instrValid    = valid_q;
  assign bus.busy          = (state == FETCH) || (state == HOLD);
  assign bus.done          = (state == DONE);
  assign bus.fault         = fault_q;

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept_start) begin
      cnt_q <= '0;
    end else if (bus.busy && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.cycleCount = cnt_q;
`endif

endmodule
